// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a shared combinational ALU
module alu_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ALUCTRL_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*WORD_WIDTH-1:0] req_a_i,
  input  logic [2*WORD_WIDTH-1:0] req_b_i,
  input  logic [2*ALUCTRL_W-1:0]  req_m_i,
  input  logic [31:0]             req_imm1_i,
  input  logic [9:0]              req_imm2_i,
  output logic [WORD_WIDTH-1:0]   alu_a_o,
  output logic [WORD_WIDTH-1:0]   alu_b_o,
  output logic [ALUCTRL_W-1:0]    alu_m_o,
  output logic [15:0]             alu_imm1_o,
  output logic [4:0]              alu_imm2_o,
  input  logic [WORD_WIDTH-1:0]   alu_c_i,
  input  logic                    alu_z_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_id_o,
  output logic [WORD_WIDTH-1:0]   rsp_c_o,
  output logic                    rsp_z_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic last_grant_q, id_q, win, accept;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: EXEC is always one cycle, RESP waits for the consumer
  always_comb
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              rsp_ready_i ? (accept ? EXEC : IDLE) : RESP;
  // arbitration and handshake; contention goes to the port that did not win last
  always_comb begin
    win = &req_valid_i ? ~last_grant_q : req_valid_i[1];
    accept = rst_n && |req_valid_i && (state_q == IDLE || (state_q == RESP && rsp_ready_i));
    req_ready_o = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
  assign rsp_valid_o = state_q == RESP;
  // operand latch on accept, response capture at the end of EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_m_o      <= '0;
      alu_imm1_o   <= '0;
      alu_imm2_o   <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_id_o     <= 1'b0;
      rsp_c_o      <= '0;
      rsp_z_o      <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_o      <= win ? req_a_i[2*WORD_WIDTH-1:WORD_WIDTH] : req_a_i[WORD_WIDTH-1:0];
        alu_b_o      <= win ? req_b_i[2*WORD_WIDTH-1:WORD_WIDTH] : req_b_i[WORD_WIDTH-1:0];
        alu_m_o      <= win ? req_m_i[2*ALUCTRL_W-1:ALUCTRL_W] : req_m_i[ALUCTRL_W-1:0];
        alu_imm1_o   <= win ? req_imm1_i[31:16] : req_imm1_i[15:0];
        alu_imm2_o   <= win ? req_imm2_i[9:5] : req_imm2_i[4:0];
        id_q         <= win;
        last_grant_q <= win;
      end
      if (state_q == EXEC) begin
        rsp_id_o <= id_q;
        rsp_c_o  <= alu_c_i;
        rsp_z_o  <= alu_z_i;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with a small external ALU
module tb_alu_arbiter;
  logic        clk = 0, rst_n = 0, rsp_ready = 0;
  logic [1:0]  req_valid = 0, req_ready;
  logic [63:0] req_a = 0, req_b = 0;
  logic [9:0]  req_m = 0, req_imm2 = 0;
  logic [31:0] req_imm1 = 0;
  logic [31:0] alu_a, alu_b, alu_c, rsp_c;
  logic [4:0]  alu_m, alu_imm2;
  logic [15:0] alu_imm1;
  logic        alu_z, rsp_valid, rsp_id, rsp_z;
  int          passed = 0, total = 0;
  localparam logic [4:0] ADD = 0, SRA = 1, SUB = 2;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_m_i(req_m), .req_imm1_i(req_imm1),
    .req_imm2_i(req_imm2), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_m_o(alu_m),
    .alu_imm1_o(alu_imm1), .alu_imm2_o(alu_imm2), .alu_c_i(alu_c), .alu_z_i(alu_z),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_c_o(rsp_c), .rsp_z_o(rsp_z)
  );

  always #5 clk = ~clk;

  assign alu_c = alu_m == ADD ? alu_a + alu_b :
                 alu_m == SRA ? 32'($signed(alu_b) >>> alu_imm2) :
                 alu_m == SUB ? alu_a - alu_b : alu_a ^ alu_b;
  assign alu_z = alu_c == 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] m, input logic [4:0] sh);
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
    req_m[p*5 +: 5] = m;
    req_imm2[p*5 +: 5] = sh;
    req_imm1[p*16 +: 16] = 16'(a);
  endtask

  initial begin
    req_valid = 2'b11;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_c", rsp_c, 0);
    tick();
    chk("reset_req_ready_held", 32'(req_ready), 0);
    tick();
    rst_n = 1;
    req_valid = 0;
    #1;
    chk("idle_no_valid_ready", 32'(req_ready), 0);
    // single op on port 0: 5 + 3
    set_port(0, 5, 3, ADD, 0);
    req_valid = 2'b01;
    rsp_ready = 1;
    #1;
    chk("p0_ready", 32'(req_ready), 2'b01);
    tick();
    req_valid = 0;
    chk("p0_alu_a", alu_a, 5);
    chk("p0_alu_b", alu_b, 3);
    chk("p0_alu_imm1", 32'(alu_imm1), 5);
    chk("p0_exec_valid", 32'(rsp_valid), 0);
    chk("p0_exec_ready", 32'(req_ready), 0);
    tick();
    chk("p0_rsp_valid", 32'(rsp_valid), 1);
    chk("p0_rsp_c", rsp_c, 8);
    chk("p0_rsp_id", 32'(rsp_id), 0);
    chk("p0_rsp_z", 32'(rsp_z), 0);
    tick();
    chk("p0_back_idle", 32'(rsp_valid), 0);
    // fresh reset so contention starts from port 0
    rst_n = 0;
    #1;
    rst_n = 1;
    set_port(0, 1, 1, ADD, 0);
    set_port(1, 10, 20, ADD, 0);
    req_valid = 2'b11;
    #1;
    chk("rr_first_ready", 32'(req_ready), 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_exec_ready", 32'(req_ready), 0);
      chk("rr_exec_valid", 32'(rsp_valid), 0);
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 1);
      chk("rr_rsp_id", 32'(rsp_id), k % 2);
      chk("rr_rsp_c", rsp_c, k % 2 ? 30 : 2);
      chk("rr_next_ready", 32'(req_ready), k % 2 ? 2'b01 : 2'b10);
      if (k == 3) req_valid = 0;
    end
    tick();
    chk("rr_idle", 32'(rsp_valid), 0);
    // port 1 arithmetic shift, consumer stalled
    set_port(1, 0, 32'h8000_0000, SRA, 4);
    req_valid = 2'b10;
    rsp_ready = 0;
    #1;
    chk("sra_ready", 32'(req_ready), 2'b10);
    tick();
    req_valid = 2'b11;
    chk("sra_alu_imm2", 32'(alu_imm2), 4);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_id", 32'(rsp_id), 1);
      chk("stall_c", rsp_c, 32'hF800_0000);
      chk("stall_ready", 32'(req_ready), 0);
      tick();
    end
    // retire and accept on the same edge
    set_port(0, 7, 7, SUB, 0);
    req_valid = 2'b01;
    rsp_ready = 1;
    #1;
    chk("b2b_ready", 32'(req_ready), 2'b01);
    tick();
    req_valid = 0;
    chk("b2b_gap_valid", 32'(rsp_valid), 0);
    chk("b2b_alu_a", alu_a, 7);
    chk("b2b_alu_m", 32'(alu_m), 32'(SUB));
    tick();
    chk("b2b_rsp_valid", 32'(rsp_valid), 1);
    chk("b2b_rsp_c", rsp_c, 0);
    chk("b2b_rsp_z", 32'(rsp_z), 1);
    chk("b2b_rsp_id", 32'(rsp_id), 0);
    tick();
    // port 1 waits behind a stalled port 0 response
    set_port(0, 4, 4, ADD, 0);
    set_port(1, 100, 1, ADD, 0);
    rsp_ready = 0;
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b10;
    tick();
    chk("wait_ready_resp", 32'(req_ready), 0);
    tick();
    chk("wait_rsp_id", 32'(rsp_id), 0);
    chk("wait_rsp_c", rsp_c, 8);
    chk("wait_alu_a_held", alu_a, 4);
    rsp_ready = 1;
    req_valid = 2'b11;
    #1;
    chk("wait_grant_p1", 32'(req_ready), 2'b10);
    tick();
    req_valid = 0;
    chk("wait_alu_a", alu_a, 100);
    tick();
    chk("wait_p1_rsp_id", 32'(rsp_id), 1);
    chk("wait_p1_rsp_c", rsp_c, 101);
    tick();
    // reset in the middle of a port 1 operation
    set_port(1, 50, 50, ADD, 0);
    req_valid = 2'b10;
    tick();
    req_valid = 0;
    chk("rst_mid_alu_a", alu_a, 50);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid_alu_a_clr", alu_a, 0);
    chk("rst_mid_rsp_c", rsp_c, 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    #1;
    rst_n = 1;
    tick();
    chk("rst_no_rsp_1", 32'(rsp_valid), 0);
    tick();
    chk("rst_no_rsp_2", 32'(rsp_valid), 0);
    chk("rst_no_rsp_c", rsp_c, 0);
    req_valid = 2'b11;
    #1;
    chk("rst_grant_p0", 32'(req_ready), 2'b01);
    tick();
    req_valid = 0;
    chk("rst_grant_alu_a", alu_a, 4);
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 32, operand/result width.
REQ-002 Parameter ALUCTRL_W, default 5, ALU control code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-port request valid (bit i = port i).
REQ-006 req_ready  output  2  per-port accept; a transfer occurs when valid and ready are high on the same edge.
REQ-007 req_a, req_b  input  2*WORD_WIDTH each  per-port operands, port i in slice i.
REQ-008 req_m  input  2*ALUCTRL_W  per-port ALU control code.
REQ-009 req_imm1  input  2*16  per-port 16-bit immediate.
REQ-010 req_imm2  input  2*5  per-port shift amount.
REQ-011 alu_a, alu_b, alu_m, alu_imm1, alu_imm2  output  WORD_WIDTH/WORD_WIDTH/ALUCTRL_W/16/5  registered operands to the shared combinational ALU.
REQ-012 alu_c  input  WORD_WIDTH  ALU result; alu_z  input  1  ALU flag.
REQ-013 rsp_valid  output  1  response valid; rsp_ready  input  1  consumer accept.
REQ-014 rsp_id  output  1  port that issued the response; rsp_c  output  WORD_WIDTH  result; rsp_z  output  1  flag.

Function
REQ-015 FSM states: IDLE (nothing in flight), EXEC (operands held, ALU evaluating), RESP (response held).
REQ-016 At most one operation in flight; no internal queue.
REQ-017 Arbitration: one valid port wins alone; both valid, the port not equal to last_grant wins (round-robin).
REQ-018 last_grant updates to the winning port only on an accepted transfer; never on stalled requests.
REQ-019 req_ready is asserted only to the winner, only in IDLE, or in RESP with rsp_ready high (back-to-back); both bits are 0 in EXEC.
REQ-020 req_ready for a port is 0 whenever that port's req_valid is 0.
REQ-021 On accept: winner's a/b/m/imm1/imm2 latched into alu_* registers, winner id latched, next state EXEC.
REQ-022 alu_* outputs hold their last values when not accepting (no change outside accept edges).
REQ-023 EXEC lasts exactly one cycle: on the next edge alu_c, alu_z, latched id are captured into rsp_c, rsp_z, rsp_id; rsp_valid set; next state RESP.
REQ-024 Latency: rsp_valid high in the second cycle after the accept edge (accept edge E0, capture edge E1).
REQ-025 RESP: rsp_valid, rsp_id, rsp_c, rsp_z stable until rsp_ready is high at an edge.
REQ-026 RESP with rsp_ready high and no new accept: rsp_valid cleared, next state IDLE.
REQ-027 RESP with rsp_ready high and a new accept on the same edge: rsp_valid cleared, new operands latched, next state EXEC.
REQ-028 rsp_valid is 0 in IDLE and EXEC; throughput is one operation per two cycles at best.
REQ-029 Result is passed through unmodified; no width conversion, no interpretation of alu_m.
REQ-030 No error or illegal-code handling; any alu_m value is forwarded.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, rsp_valid 0, rsp_id 0, rsp_c 0, rsp_z 0, all alu_* 0, last_grant 1 (port 0 wins first contention).
REQ-032 Reset during EXEC or RESP discards the in-flight operation; no response is emitted after reset release.
REQ-033 req_ready is 0 while rst_n is low; first accept possible on the first edge after release.

Verification
REQ-034 Port 0 alone: a=5, b=3, m=ADD, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_c=8, rsp_id=0, back to IDLE.
REQ-035 Both ports valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1, one response per 2 cycles.
REQ-036 Port 1: b=0x80000000, imm2=4, m=SRA, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id=1, rsp_c stable throughout; req_ready both 0 during stall.
REQ-037 RESP with rsp_ready=1 and port 0 valid same edge -> response retired and new op accepted same edge; rsp_valid low exactly one cycle.
REQ-038 rst_n pulsed low during EXEC of port 1 op -> all outputs reset immediately, no response after release, next contention grants port 0.
REQ-039 Port 1 requests while port 0 stalled by rsp_ready=0 -> no accept until rsp_ready high; last_grant unchanged by the stall.
